// File: rtl/dot_field.sv
// Maze dot / power-pellet field: eaten bitmap, a collision scanner that tests one dot
// per clock after each movement tick, score keeping, and a registered renderer lookup port.
module dot_field #(
  parameter  int COLS     = 8,
  parameter  int ROWS     = 4,
  parameter  int X0       = 60,
  parameter  int Y0       = 20,
  parameter  int PITCH    = 60,
  parameter  int HIT_TOL  = 4,
  parameter  int DOT_PTS  = 10,
  parameter  int PWR_PTS  = 50,
  localparam int NUM_DOTS = COLS * ROWS,
  localparam int IDX_W    = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic             restart_i,
  input  logic [9:0]       pX_i,
  input  logic [9:0]       pY_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [9:0]       rd_x_o,
  output logic [9:0]       rd_y_o,
  output logic             rd_present_o,
  output logic             rd_power_o,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             dot_eaten_o,
  output logic             power_eaten_o,
  output logic [IDX_W:0]   dots_left_o,
  output logic [15:0]      score_o,
  output logic             level_clear_o
);

  localparam logic [IDX_W:0]   NUM_DOTS_W = (IDX_W + 1)'(NUM_DOTS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [9:0]          pXl_q;
  logic [9:0]          pYl_q;
  logic [NUM_DOTS-1:0] eaten_q;
  logic [IDX_W:0]      dotsLeft_q;
  logic [15:0]         score_q;
  logic                dotPulse_q;
  logic                pwrPulse_q;
  logic [9:0]          rdX_q;
  logic [9:0]          rdY_q;
  logic                rdPresent_q;
  logic                rdPower_q;

  // Dot coordinates and pellet flags are elaboration-time constants (a small ROM).
  logic [9:0]          dotX [NUM_DOTS];
  logic [9:0]          dotY [NUM_DOTS];
  logic [NUM_DOTS-1:0] powerMask;

  for (genvar g = 0; g < NUM_DOTS; g++) begin : gen_dots
    assign dotX[g]      = 10'(X0 + (g % COLS) * PITCH);
    assign dotY[g]      = 10'(Y0 + (g / COLS) * PITCH);
    assign powerMask[g] = (g == 0) || (g == COLS - 1) ||
                          (g == NUM_DOTS - COLS) || (g == NUM_DOTS - 1);
  end

  logic [10:0] ax, bx, ay, by, dx, dy;
  logic        hitNow;
  logic [15:0] pts;
  logic [16:0] scoreSum;
  logic        rdValid;

  // Unsigned 11-bit distances never wrap, so a far-away dot can never look close.
  always_comb begin
    ax       = {1'b0, pXl_q};
    bx       = {1'b0, dotX[idx_q]};
    ay       = {1'b0, pYl_q};
    by       = {1'b0, dotY[idx_q]};
    dx       = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy       = (ay >= by) ? (ay - by) : (by - ay);
    hitNow   = (state_q == SCAN) && !eaten_q[idx_q] &&
               (dx <= 11'(HIT_TOL)) && (dy <= 11'(HIT_TOL));
    pts      = powerMask[idx_q] ? 16'(PWR_PTS) : 16'(DOT_PTS);
    scoreSum = {1'b0, score_q} + {1'b0, pts};
    rdValid  = {1'b0, rd_idx_i} < NUM_DOTS_W;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pXl_q       <= '0;
      pYl_q       <= '0;
      eaten_q     <= '0;
      dotsLeft_q  <= NUM_DOTS_W;
      score_q     <= '0;
      dotPulse_q  <= 1'b0;
      pwrPulse_q  <= 1'b0;
      rdX_q       <= '0;
      rdY_q       <= '0;
      rdPresent_q <= 1'b0;
      rdPower_q   <= 1'b0;
    end else begin
      dotPulse_q <= 1'b0;
      pwrPulse_q <= 1'b0;

      if (rdValid) begin
        rdX_q       <= dotX[rd_idx_i];
        rdY_q       <= dotY[rd_idx_i];
        rdPresent_q <= !eaten_q[rd_idx_i];
        rdPower_q   <= powerMask[rd_idx_i];
      end else begin
        rdX_q       <= '0;
        rdY_q       <= '0;
        rdPresent_q <= 1'b0;
        rdPower_q   <= 1'b0;
      end

      // Restart wins over everything the scanner would do this cycle, including a hit.
      if (restart_i) begin
        eaten_q    <= '0;
        dotsLeft_q <= NUM_DOTS_W;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (tick_i) begin
              pXl_q   <= pX_i;
              pYl_q   <= pY_i;
              idx_q   <= '0;
              state_q <= SCAN;
            end
          end
          SCAN: begin
            if (hitNow) begin
              eaten_q[idx_q] <= 1'b1;
              dotsLeft_q     <= dotsLeft_q - (IDX_W + 1)'(1);
              score_q        <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
              dotPulse_q     <= !powerMask[idx_q];
              pwrPulse_q     <= powerMask[idx_q];
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rd_x_o        = rdX_q;
  assign rd_y_o        = rdY_q;
  assign rd_present_o  = rdPresent_q;
  assign rd_power_o    = rdPower_q;
  assign busy_o        = (state_q == SCAN);
  assign scan_done_o   = (state_q == DONE);
  assign dot_eaten_o   = dotPulse_q;
  assign power_eaten_o = pwrPulse_q;
  assign dots_left_o   = dotsLeft_q;
  assign score_o       = score_q;
  assign level_clear_o = (dotsLeft_q == '0);

endmodule

// File: doc/dot_field.md
Name: dot_field

Overview:
- Parametrised grid of collectible dots and power pellets for the maze; successor to the fixed 32-dot array.
- Dot coordinates are generated from grid parameters. Per-dot eaten state is held in a bitmap.
- Pac-Man collision is checked by a sequential scanner that tests one dot per clock, triggered once per movement tick, instead of N parallel comparators.
- Outputs remaining count, score, eat pulses and level-clear to game control, and provides a registered lookup port for the sprite renderer.

Parameters:
- COLS, 8, dots per row.
- ROWS, 4, dot rows; NUM_DOTS = COLS*ROWS (max 1024).
- X0, 60, x coordinate of column 0.
- Y0, 20, y coordinate of row 0.
- PITCH, 60, spacing between adjacent dots, both axes.
- HIT_TOL, 4, collision tolerance in pixels per axis (inclusive).
- DOT_PTS, 10, score per normal dot.
- PWR_PTS, 50, score per power pellet.
- IDX_W, $clog2(NUM_DOTS), index width (derived; at least 1).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse: Pac-Man position updated, start a scan.
- restart  in  1  one-cycle pulse: refill all dots for the next level; score is kept.
- pX  in  10  Pac-Man centre x; sampled at tick.
- pY  in  10  Pac-Man centre y; sampled at tick.
- rd_idx  in  IDX_W  renderer query index.
- rd_x  out  10  x coordinate of rd_idx (registered).
- rd_y  out  10  y coordinate of rd_idx (registered).
- rd_present  out  1  1 = dot at rd_idx not yet eaten (registered).
- rd_power  out  1  1 = rd_idx is a power pellet (registered).
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at the end of a scan.
- dot_eaten  out  1  one-cycle pulse per normal dot consumed.
- power_eaten  out  1  one-cycle pulse per power pellet consumed.
- dots_left  out  IDX_W+1  count of uneaten dots.
- score  out  16  accumulated points, saturating at 16'hFFFF.
- level_clear  out  1  level on while dots_left == 0.

Behaviour:
- Dot i: col = i % COLS, row = i / COLS; x = X0 + col*PITCH, y = Y0 + row*PITCH, computed at 10 bits.
- Power pellets are the four corners: i = 0, COLS-1, NUM_DOTS-COLS, NUM_DOTS-1. Duplicates collapse when COLS or ROWS is 1.
- Reset:
  - eaten bitmap all 0; dots_left = NUM_DOTS; score = 0.
  - FSM in IDLE; busy, scan_done, dot_eaten, power_eaten = 0.
  - rd_* outputs = 0; level_clear = 0.
- FSM IDLE:
  - tick latches pX/pY into internal registers, clears the scan index, goes to SCAN, and sets busy next cycle.
- FSM SCAN:
  - Each cycle evaluates dot idx.
  - Hit = !eaten[idx] && |pXl - x| <= HIT_TOL && |pYl - y| <= HIT_TOL, using unsigned absolute difference at 11 bits with no wrap.
  - On hit: set eaten[idx], decrement dots_left, add the points, and pulse dot_eaten or power_eaten in the next cycle.
  - Multiple hits per scan are allowed, at most one per cycle.
  - When idx == NUM_DOTS-1, go to DONE.
- FSM DONE:
  - scan_done = 1 for one cycle, busy drops to 0, return to IDLE.
- Timing:
  - tick at cycle t → busy high t+1 .. t+NUM_DOTS.
  - Eat pulse for dot k occurs at cycle t+k+2.
  - scan_done occurs at t+NUM_DOTS+1.
- tick while busy or in DONE is ignored; no queueing.
- restart:
  - Has priority over scan activity.
  - Clears the bitmap and sets dots_left = NUM_DOTS in the next cycle.
  - Aborts any scan to IDLE with no scan_done.
  - Suppresses any pending eat pulse and its points for that cycle.
  - score is unchanged.
- Reset has priority over restart and tick.
- score: add saturates at 16'hFFFF. dots_left never underflows, because hits only occur on uneaten dots.
- level_clear: combinational from dots_left == 0; remains set until restart or Reset.
- Lookup port:
  - rd_x/rd_y/rd_present/rd_power reflect rd_idx one cycle later.
  - rd_present uses the bitmap value at the sampling edge.
  - rd_idx >= NUM_DOTS returns all zeros.
- The renderer read path is independent of the scan; both run the same cycle.

Test Plan:
- COLS=4, ROWS=2, X0=20, Y0=20, PITCH=40, HIT_TOL=4 for all scenarios.
- Reset, then rd_idx=5 → next cycle rd_x=60, rd_y=60, rd_present=1, rd_power=0; dots_left=8, score=0.
- pX=62, pY=18, tick → one dot_eaten pulse at t+3, scan_done at t+9, dots_left=7, score=10.
- Repeat the same tick → no pulse, dots_left=7, score=10.
- pX=140, pY=60 (dot 7, power), tick → power_eaten pulse, score=60.
- pX=25, pY=20 (|dx|=5) → no hit.
- Eat all 8 dots via successive ticks → dots_left=0, level_clear=1.
- Then restart → dots_left=8, level_clear=0, score unchanged.
- tick with pX=20, pY=20; tick again at t+3 (ignored); restart at t+4 (aborts) → busy=0 at t+5, no scan_done.
- Dot 0 stays uneaten, since the restart clears the bitmap; score keeps the 50 from the dot-0 power pellet eaten at t+2.
- Preload score near 16'hFFF0 via repeated eats/restarts, then eat a power pellet → score=16'hFFFF.
